// File: rtl/dedisp_pkg.sv
// dedisp_pkg -- shared constants and FSM state type for the dedispersion
// frame packer.
//   HDR_WORD : frame sync word written first on header frames
//   TS_W     : timestamp width
//   OUT_W    : FIFO word width
//   state_t  : packer FSM states (ST_CSUM exists only when
//              DEDISP_PACK_CHKSUM_EN is defined)
package dedisp_pkg;

  localparam logic [15:0] HDR_WORD = 16'hFFFF;
  localparam int          TS_W     = 40;
  localparam int          OUT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_HDR   = 3'd2,
    ST_TSH   = 3'd3,
    ST_TSM   = 3'd4,
    ST_TSL   = 3'd5,
`ifdef DEDISP_PACK_CHKSUM_EN
    ST_DATA  = 3'd6,
    ST_CSUM  = 3'd7
`else
    ST_DATA  = 3'd6
`endif
  } state_t;

  // Number of OUT_W-bit words needed to carry one channel of data_w bits.
  function automatic int words_per_chan(input int data_w);
    return (data_w + OUT_W - 1) / OUT_W;
  endfunction

endpackage

// File: rtl/dedisp_sync_fifo.sv
// dedisp_sync_fifo -- single-clock FIFO with registered read data and a
// free-space count, used as the packer's output store.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en/wr_data : write port (ignored when full unless a read frees a slot)
//   rd_en      : read request, ignored while empty
//   rd_data    : registered, valid the cycle after an accepted read
//   empty      : no words stored
//   free       : DEPTH minus current occupancy
module dedisp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok = rd_en && (count_reg != '0);
  // A full FIFO can still take a write when the same cycle pops a word.
  assign wr_ok = wr_en && ((count_reg != DEPTH_C) || rd_ok);

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign empty   = (count_reg == '0);
  assign free    = DEPTH_C - count_reg;

endmodule

// File: rtl/dedisp_frame_packer.sv
// dedisp_frame_packer -- packs one frame of NCH power channels (plus an
// occasional header and 40-bit timestamp) into 16-bit FIFO words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   dready      : frame strobe, a frame starts on its rising edge
//   power_in    : channel k at [k*DATA_W +: DATA_W]
//   timer_flag  : 40-bit timestamp captured with the frame
//   rd_en, dout, empty : FIFO read side (dout valid the cycle after rd_en)
//   frame_cnt   : accepted frames (wraps)
//   drop_cnt    : dropped frames (saturates)
//   ovf         : sticky drop flag
// Optional feature macro: DEDISP_PACK_CHKSUM_EN appends an XOR checksum word.
module dedisp_frame_packer
  import dedisp_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 64,
  parameter int HDR_PERIOD = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dready,
  input  logic [NCH*DATA_W-1:0] power_in,
  input  logic [TS_W-1:0]       timer_flag,
  input  logic                  rd_en,
  output logic [OUT_W-1:0]      dout,
  output logic                  empty,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  ovf
);

  localparam int WPC      = words_per_chan(DATA_W);
  localparam int NW       = NCH * WPC;
  localparam int SR_W     = NW * OUT_W;
  localparam int CH_PAD_W = WPC * OUT_W;
`ifdef DEDISP_PACK_CHKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int WC_W = $clog2(NW + 1);
  localparam logic [AW:0]     L_HDR  = LW'(4 + NW + CS);
  localparam logic [AW:0]     L_DATA = LW'(NW + CS);
  localparam logic [15:0]     HDR_P  = 16'(HDR_PERIOD);
  localparam logic [WC_W-1:0] WC_END = WC_W'(NW - 1);

  state_t            state_reg, state_next;
  logic              dready_d_reg;
  logic [TS_W-1:0]   ts_reg;
  logic [SR_W-1:0]   data_sr_reg;
  logic [WC_W-1:0]   word_cnt_reg;
  logic [15:0]       frame_cnt_reg;
  logic [15:0]       drop_cnt_reg;
  logic              ovf_reg;
`ifdef DEDISP_PACK_CHKSUM_EN
  logic [OUT_W-1:0]  csum_reg;
`endif

  logic              dready_edge;
  logic              is_hdr;
  logic [AW:0]       frame_len;
  logic [AW:0]       fifo_free;
  logic              fits;
  logic              drop_evt;
  logic              wr_en;
  logic [OUT_W-1:0]  wr_data;
  logic [SR_W-1:0]   seq_words;

  assign dready_edge = dready & ~dready_d_reg;
  assign is_hdr      = (frame_cnt_reg % HDR_P) == 16'd0;
  assign frame_len   = is_hdr ? L_HDR : L_DATA;
  assign fits        = (fifo_free >= frame_len);
  // Edges that arrive while a frame is in flight are lost, as are frames
  // that would not fit completely in the FIFO.
  assign drop_evt    = ((state_reg == ST_CHECK) && !fits) ||
                       ((state_reg != ST_IDLE) && dready_edge);

  // Reorder the channels into output order at capture time so the DATA
  // phase only shifts: word j of the frame body sits at the top after j shifts.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CH_PAD_W-1:0] ch_pad;
    assign ch_pad = CH_PAD_W'(power_in[gi*DATA_W +: DATA_W]);
    for (genvar gj = 0; gj < WPC; gj++) begin : g_word
      assign seq_words[(NW-1-(gi*WPC+gj))*OUT_W +: OUT_W] =
        ch_pad[(WPC-1-gj)*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_data    = '0;
    case (state_reg)
      ST_IDLE:  if (dready_edge) state_next = ST_CHECK;
      ST_CHECK: begin
        if (fits) state_next = is_hdr ? ST_HDR : ST_DATA;
        else      state_next = ST_IDLE;
      end
      ST_HDR: begin
        wr_en = 1'b1; wr_data = HDR_WORD; state_next = ST_TSH;
      end
      ST_TSH: begin
        wr_en = 1'b1; wr_data = {8'h00, ts_reg[39:32]}; state_next = ST_TSM;
      end
      ST_TSM: begin
        wr_en = 1'b1; wr_data = ts_reg[31:16]; state_next = ST_TSL;
      end
      ST_TSL: begin
        wr_en = 1'b1; wr_data = ts_reg[15:0]; state_next = ST_DATA;
      end
      ST_DATA: begin
        wr_en   = 1'b1;
        wr_data = data_sr_reg[SR_W-1 -: OUT_W];
        if (word_cnt_reg == WC_END) begin
`ifdef DEDISP_PACK_CHKSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_IDLE;
`endif
        end
      end
`ifdef DEDISP_PACK_CHKSUM_EN
      ST_CSUM: begin
        wr_en = 1'b1; wr_data = csum_reg; state_next = ST_IDLE;
      end
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dready_d_reg  <= 1'b0;
      ts_reg        <= '0;
      data_sr_reg   <= '0;
      word_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dready_d_reg <= dready;
      if ((state_reg == ST_IDLE) && dready_edge) begin
        ts_reg      <= timer_flag;
        data_sr_reg <= seq_words;
      end else if (state_reg == ST_DATA) begin
        data_sr_reg <= data_sr_reg << OUT_W;
      end
      if (state_reg == ST_DATA) word_cnt_reg <= word_cnt_reg + WC_W'(1);
      else                      word_cnt_reg <= '0;
      if ((state_reg == ST_CHECK) && fits) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      if (drop_evt) begin
        ovf_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

`ifdef DEDISP_PACK_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg <= '0;
    end else if (state_reg == ST_CHECK) begin
      csum_reg <= '0;
    end else if (wr_en) begin
      csum_reg <= csum_reg ^ wr_data;
    end
  end
`endif

  dedisp_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (dout),
    .empty   (empty),
    .free    (fifo_free)
  );

  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_dedisp_frame_packer.sv
// tb_dedisp_frame_packer -- directed self-checking bench for
// dedisp_frame_packer (NCH=4, DATA_W=24, FIFO_DEPTH=16, HDR_PERIOD=2048).
// Honours DEDISP_PACK_CHKSUM_EN for the expected frame length and checksum.
module tb_dedisp_frame_packer;

  localparam int NCH        = 4;
  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 16;
  localparam int HDR_PERIOD = 2048;
`ifdef DEDISP_PACK_CHKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int LD = 2 * NCH + CS;
  localparam int LH = LD + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dready = 1'b0;
  logic [95:0] power_in = '0;
  logic [39:0] timer_flag = '0;
  logic        rd_en = 1'b0;
  logic [15:0] dout;
  logic        empty;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int m_occ = 0;
  int m_fcnt = 0;
  int m_drops = 0;

  always #5 clk = ~clk;

  dedisp_frame_packer #(
    .NCH        (NCH),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .HDR_PERIOD (HDR_PERIOD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dready     (dready),
    .power_in   (power_in),
    .timer_flag (timer_flag),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .ovf        (ovf)
  );

  // Expected FIFO contents of one accepted frame.
  function automatic void push_frame(input bit hdr, input logic [39:0] ts,
                                     input logic [95:0] pw);
    logic [15:0] cs;
    logic [23:0] ch;
    cs = 16'h0000;
    if (hdr) begin
      exp_q.push_back(16'hFFFF);            cs = cs ^ 16'hFFFF;
      exp_q.push_back({8'h00, ts[39:32]});  cs = cs ^ {8'h00, ts[39:32]};
      exp_q.push_back(ts[31:16]);           cs = cs ^ ts[31:16];
      exp_q.push_back(ts[15:0]);            cs = cs ^ ts[15:0];
    end
    for (int k = 0; k < NCH; k++) begin
      ch = pw[k*24 +: 24];
      exp_q.push_back({8'h00, ch[23:16]});  cs = cs ^ {8'h00, ch[23:16]};
      exp_q.push_back(ch[15:0]);            cs = cs ^ ch[15:0];
    end
    if (CS == 1) exp_q.push_back(cs);
  endfunction

  // One dready pulse; the model decides accept/drop from its own occupancy.
  task automatic send_frame(input logic [95:0] pw, input logic [39:0] ts);
    bit hdr;
    int len;
    hdr = (m_fcnt % HDR_PERIOD) == 0;
    len = hdr ? LH : LD;
    if (FIFO_DEPTH - m_occ >= len) begin
      push_frame(hdr, ts, pw);
      m_occ  += len;
      m_fcnt  = (m_fcnt + 1) & 16'hFFFF;
      $display("frame ts=%h hdr=%0d len=%0d accepted", ts, hdr, len);
    end else begin
      m_drops++;
      len = 0;
      $display("frame ts=%h len=%0d dropped (model)", ts, hdr ? LH : LD);
    end
    @(negedge clk);
    power_in = pw; timer_flag = ts; dready = 1'b1;
    @(negedge clk);
    dready = 1'b0;
    repeat (len + 3) @(negedge clk);
  endtask

  task automatic read_n(input int n);
    got_q.delete();
    @(negedge clk);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got_q.push_back(dout);
      $display("read word %0d = %h", i, dout);
    end
    rd_en = 1'b0;
    m_occ -= n;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %h expected 0000", frame_cnt); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst_n = 1'b1;
    m_occ = 0; m_fcnt = 0; m_drops = 0;
    @(negedge clk);
  endtask

  task automatic test_first_frame;
    logic [95:0] pw;
    logic [39:0] ts;
    pw = {24'h778899, 24'h445566, 24'h112233, 24'h0A0B0C};
    ts = 40'h12_3456_789A;
    exp_q.delete();
    push_frame(1'b1, ts, pw);
    m_occ = LH; m_fcnt = 1;
    @(negedge clk);
    power_in = pw; timer_flag = ts; dready = 1'b1;
    @(negedge clk);           // edge sampled, FSM in CHECK
    dready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_check_empty: got %b expected 1", empty); end
    @(negedge clk);           // HDR write in progress
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_write_early: got %b expected 1", empty); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL first_frame_cnt: got %0d expected 1", frame_cnt); end
    @(negedge clk);           // first word landed
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL first_write_time: got %b expected 0", empty); end
    repeat (LH + 1) @(negedge clk);
    read_n(LH);
    for (int i = 0; i < LH; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL first_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_drained: got %b expected 1", empty); end
  endtask

  task automatic test_no_header;
    exp_q.delete();
    send_frame({24'hA1B2C3, 24'hD4E5F6, 24'h010203, 24'hFEDCBA}, 40'hAB_CDEF_0123);
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL nohdr_frame_cnt: got %0d expected 2", frame_cnt); end
    read_n(LD);
    for (int i = 0; i < LD; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL nohdr_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nohdr_drained: got %b expected 1", empty); end
  endtask

  task automatic test_overflow;
    int n;
    exp_q.delete();
    send_frame({24'h111111, 24'h222222, 24'h333333, 24'h444444}, 40'h01_0000_0001);
    send_frame({24'h555555, 24'h666666, 24'h777777, 24'h888888}, 40'h01_0000_0002);
    send_frame({24'h999999, 24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC}, 40'h01_0000_0003);
    checks++; if (drop_cnt !== 16'(m_drops)) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected %0d", drop_cnt, m_drops); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    checks++; if (frame_cnt !== 16'(m_fcnt)) begin errors++; $display("FAIL ovf_frame_cnt: got %0d expected %0d", frame_cnt, m_fcnt); end
    n = m_occ;
    read_n(n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_occupancy: got empty=%b expected 1", empty); end
  endtask

  task automatic test_reedge;
    logic [95:0] pw;
    logic [39:0] ts;
    pw = {24'h13579B, 24'h2468AC, 24'hF0F0F0, 24'h0F0F0F};
    ts = 40'h77_6655_4433;
    exp_q.delete();
    push_frame((m_fcnt % HDR_PERIOD) == 0, ts, pw);
    m_occ += LD; m_fcnt++; m_drops++;
    @(negedge clk);
    power_in = pw; timer_flag = ts; dready = 1'b1;
    @(negedge clk);
    dready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    power_in = {24'hDEADBE, 24'hDEADBE, 24'hDEADBE, 24'hDEADBE};
    timer_flag = 40'hFF_FFFF_FFFF;
    dready = 1'b1;            // sampled 3 cycles after the first edge
    @(negedge clk);
    dready = 1'b0;
    $display("re-edge during frame ts=%h", ts);
    repeat (LD + 3) @(negedge clk);
    checks++; if (drop_cnt !== 16'(m_drops)) begin errors++; $display("FAIL reedge_drop_cnt: got %0d expected %0d", drop_cnt, m_drops); end
    checks++; if (frame_cnt !== 16'(m_fcnt)) begin errors++; $display("FAIL reedge_frame_cnt: got %0d expected %0d", frame_cnt, m_fcnt); end
    read_n(LD);
    for (int i = 0; i < LD; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reedge_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reedge_drained: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    power_in = {24'h123456, 24'h654321, 24'hABCDEF, 24'hFEDCBA};
    timer_flag = 40'h00_1111_2222;
    dready = 1'b1;
    @(negedge clk);
    dready = 1'b0;
    @(negedge clk);
    @(negedge clk);           // FSM is writing DATA words
    #2 rst_n = 1'b0;
    #1;
    $display("reset asserted mid-frame");
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL rstmid_dout: got %h expected 0000", dout); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", ovf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_occ = 0; m_fcnt = 0; m_drops = 0;
    exp_q.delete();
    send_frame({24'h00CAFE, 24'h00BEEF, 24'h0000AA, 24'h000055}, 40'h9A_BCDE_F012);
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_next_cnt: got %0d expected 1", frame_cnt); end
    read_n(LH);
    for (int i = 0; i < LH; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_hdr_period;
    rd_en = 1'b1;             // drain continuously while frames stream in
    while (m_fcnt < HDR_PERIOD) begin
      @(negedge clk);
      power_in = {32'h0, m_fcnt[31:0], m_fcnt[31:0]};
      timer_flag = 40'(m_fcnt);
      dready = 1'b1;
      @(negedge clk);
      dready = 1'b0;
      repeat (LD + 3) @(negedge clk);
      m_fcnt++;
    end
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    $display("streamed up to frame_cnt=%0d", m_fcnt);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty); end
    checks++; if (frame_cnt !== 16'd2048) begin errors++; $display("FAIL stream_frame_cnt: got %0d expected 2048", frame_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL stream_drop_cnt: got %0d expected 0", drop_cnt); end
    m_occ = 0;
    exp_q.delete();
    send_frame({24'h000000, 24'h000000, 24'h000000, 24'h000000}, 40'h12_3456_789A);
    checks++; if (frame_cnt !== 16'd2049) begin errors++; $display("FAIL period_frame_cnt: got %0d expected 2049", frame_cnt); end
    read_n(LH);
    for (int i = 0; i < LH; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL period_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_no_header();
    test_overflow();
    test_reedge();
    test_reset_mid();
    test_hdr_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dedisp_frame_packer.md
DEDISP_FRAME_PACKER -- requirements
Module: dedisp_frame_packer

Interface
REQ-001 SHALL have parameter NCH, default 4: power channels per frame, 1..16.
REQ-002 SHALL have parameter DATA_W, default 24: bits per channel, 1..64.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64: words, power of 2, at least the maximum frame length.
REQ-004 SHALL have parameter HDR_PERIOD, default 2048: header plus timestamp emitted on frames where frame_cnt mod HDR_PERIOD == 0.
REQ-005 SHALL have port clk, input, 1: single clock for the whole block.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port dready, input, 1: frame strobe; a frame starts on its rising edge.
REQ-008 SHALL have port power_in, input, NCH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port timer_flag, input, 40: timestamp.
REQ-010 SHALL have port rd_en, input, 1: FIFO read request.
REQ-011 SHALL have port dout, output, 16: FIFO read data.
REQ-012 SHALL have port empty, output, 1: FIFO empty.
REQ-013 SHALL have port frame_cnt, output, 16: accepted frames, wraps.
REQ-014 SHALL have port drop_cnt, output, 16: dropped frames, saturates at 0xFFFF.
REQ-015 SHALL have port ovf, output, 1: sticky, set on any drop.

Function
REQ-016 SHALL detect rising edges of dready with a 1-cycle delayed copy; on an edge, SHALL capture power_in and timer_flag into holding registers in the same cycle.
REQ-017 SHALL use WPC = ceil(DATA_W/16) words per channel; frame length L = 4*H + NCH*WPC (+1 with checksum), where H=1 on a header frame.
REQ-018 SHALL run the FSM IDLE -> CHECK -> [HDR -> TSH -> TSM -> TSL] -> DATA -> [CSUM] -> IDLE, writing one FIFO word per cycle in HDR through CSUM.
REQ-019 SHALL write the word sequence 0xFFFF, {8'h00, ts[39:32]}, ts[31:16], ts[15:0], then channels 0..NCH-1, each MS word first, the top word zero-extended.
REQ-020 In CHECK, SHALL accept the frame if FIFO free space >= L; otherwise it SHALL drop the whole frame (no partial writes), increment drop_cnt, set ovf, and return to IDLE.
REQ-021 On acceptance, SHALL increment frame_cnt; H is evaluated on the pre-increment frame_cnt.
REQ-022 First write SHALL occur 2 cycles after the rising-edge sample; the last write at edge + 1 + L.
REQ-023 A dready rising edge when the FSM is not IDLE SHALL be dropped: drop_cnt increments, ovf sets, and the in-flight frame continues unaltered.
REQ-024 FIFO: dout SHALL be registered and valid on the cycle after rd_en with empty=0; rd_en while empty SHALL be ignored; simultaneous read and write SHALL both complete.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be FIFO-width log2(FIFO_DEPTH)+1.

Reset
REQ-026 On rst_n=0, the block SHALL be asynchronously reset to: FSM IDLE, FIFO empty (empty=1), dout=0, frame_cnt=0, drop_cnt=0, ovf=0, holding registers 0, delayed dready copy 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first frame after reset is a header frame.

Configuration
REQ-028 With DEDISP_PACK_CHKSUM_EN defined, the block SHALL append a CSUM word equal to the XOR of all preceding words of the frame, and L includes it.
REQ-029 Without DEDISP_PACK_CHKSUM_EN, the block SHALL have no CSUM state and no extra word.

Structure
REQ-030 Package dedisp_pkg SHALL hold HDR_WORD=16'hFFFF, TS_W=40, OUT_W=16, and the FSM state enum.
REQ-031 Storage SHALL be the sub-module dedisp_sync_fifo (parameters WIDTH, DEPTH), which exposes a free-space count.

Verification
REQ-032 Defaults, first frame, ts=40'h12_3456_789A, ch0..3=24'h0A0B0C.. -> FIFO holds FFFF, 0012, 3456, 789A, 000A, 0B0C, ... (12 words); frame_cnt=1.
REQ-033 Second frame -> only 8 data words, no header; frame 2048 (cnt wrapped mod HDR_PERIOD) -> header present.
REQ-034 No reads, repeated frames with FIFO_DEPTH=16 -> frame 2 dropped whole; drop_cnt=1, ovf=1, FIFO count unchanged.
REQ-035 dready re-edge 3 cycles into a frame -> drop_cnt+1, in-flight frame complete and intact.
REQ-036 rst_n low mid-DATA -> empty=1 and counters 0 immediately; next frame carries header.
REQ-037 With DEDISP_PACK_CHKSUM_EN, a frame of all-zero data -> last word = FFFF^0012^3456^789A.
